// File: rtl/func_task_typedef_restore.sv
// Restore stage for the add-one transform. Tagged words are decremented
// (mod 2^DATA_W), untagged words pass through. Restored words are held in
// a show-ahead FIFO drained by a valid/ready handshake. A saturating counter
// tracks how many tagged words have been delivered.
module func_task_typedef_restore #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        val_in,
  input  logic                     enable,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DATA_W-1:0]        val_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [15:0]              dec_count,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [PtrW-1:0]   ptr_t;
  typedef logic [LvlW-1:0]   lvl_t;

  typedef struct packed {
    logic  tag;
    data_t data;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty,
    StPartial,
    StFull
  } occ_e;

  // Inverse of add-one; wraps 0 to all-ones when tagged.
  function automatic data_t restore(input data_t v, input logic tag);
    return tag ? data_t'(v - data_t'(1)) : v;
  endfunction

  // Builds the entry, the one-hot write strobe and the advanced write pointer.
  task automatic write_entry(
    input  ptr_t             wp,
    input  logic             tag,
    input  data_t            data,
    output logic [DEPTH-1:0] we,
    output entry_t           e,
    output ptr_t             wp_n
  );
    we     = '0;
    we[wp] = 1'b1;
    e.tag  = tag;
    e.data = data;
    wp_n   = wp + ptr_t'(1);
  endtask

  occ_e             state_q, state_d;
  lvl_t             level_q, level_d;
  ptr_t             wptr_q, wptr_d;
  ptr_t             rptr_q, rptr_d;
  logic [15:0]      dec_q, dec_d;
  entry_t           mem_q [DEPTH];
  logic [DEPTH-1:0] mem_we;
  entry_t           wentry;
  entry_t           head;
  logic             push;
  logic             pop;

  // Handshake and show-ahead outputs; all derived from registered state only.
  always_comb begin
    in_ready  = (state_q != StFull);
    out_valid = (state_q != StEmpty);
    head      = mem_q[rptr_q];
    val_out   = out_valid ? head.data : '0;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    level     = level_q;
    dec_count = dec_q;
  end

  // Occupancy FSM: tracks EMPTY / PARTIAL / FULL alongside the level count.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    unique case (state_q)
      StEmpty: begin
        if (push) begin
          level_d = lvl_t'(1);
          state_d = StPartial;
        end
      end
      StPartial: begin
        if (push && !pop) begin
          level_d = level_q + lvl_t'(1);
          if (level_d == lvl_t'(DEPTH)) state_d = StFull;
        end else if (pop && !push) begin
          level_d = level_q - lvl_t'(1);
          if (level_d == '0) state_d = StEmpty;
        end
      end
      StFull: begin
        // A pop while full never admits a push in the same cycle.
        if (pop) begin
          level_d = level_q - lvl_t'(1);
          state_d = StPartial;
        end
      end
      default: begin
        state_d = StEmpty;
        level_d = '0;
      end
    endcase
  end

  // Write side: restore at accept time and advance the write pointer.
  always_comb begin
    wptr_d = wptr_q;
    mem_we = '0;
    wentry = '0;
    if (push) begin
      write_entry(wptr_q, enable, restore(val_in, enable), mem_we, wentry, wptr_d);
    end
  end

  // Read side: advance on pop and count delivered tagged words, saturating.
  always_comb begin
    rptr_d = rptr_q;
    dec_d  = dec_q;
    if (pop) begin
      rptr_d = rptr_q + ptr_t'(1);
      if (head.tag && (dec_q != 16'hFFFF)) dec_d = dec_q + 16'd1;
    end
  end

  // Control state with synchronous reset; buffered words are simply abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      dec_q   <= dec_d;
    end
  end

  // Storage array; contents are never observed while out_valid is low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (mem_we[i]) mem_q[i] <= wentry;
    end
  end

endmodule

// File: tb/tb_func_task_typedef_restore.sv
// Bench for func_task_typedef_restore: queue-based reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_func_task_typedef_restore;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] val_in = '0;
  logic        enable = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] val_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] dec_count;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Reference model state.
  typedef struct {
    bit tag;
    int data;
  } item_t;
  item_t q[$];
  int    popped[$];
  int    m_dec = 0;

  func_task_typedef_restore #(
    .DATA_W(16),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .val_in   (val_in),
    .enable   (enable),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .val_out  (val_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dec_count(dec_count),
    .level    (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge, from the pre-edge occupancy.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_dec = 0;
    end else begin
      bit do_push;
      bit do_pop;
      item_t it;
      do_push = in_valid && (q.size() != DEPTH);
      do_pop  = out_ready && (q.size() != 0);
      if (do_pop) begin
        it = q.pop_front();
        popped.push_back(it.data);
        if (it.tag && m_dec < 65535) m_dec++;
      end
      if (do_push) begin
        it.tag  = enable;
        it.data = enable ? (int'(val_in) + 65535) % 65536 : int'(val_in);
        q.push_back(it);
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("m_in_ready", int'(in_ready), int'(q.size() != DEPTH));
      chk("m_out_valid", int'(out_valid), int'(q.size() != 0));
      chk("m_val_out", int'(val_out), (q.size() != 0) ? q[0].data : 0);
      chk("m_level", int'(level), q.size());
      chk("m_dec_count", int'(dec_count), m_dec);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    popped.delete();
  endtask

  initial begin
    // Reset then idle.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checking = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_val_out", int'(val_out), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_dec", int'(dec_count), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    // Single restore.
    val_in = 16'h0011; enable = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("one_out_valid", int'(out_valid), 1);
    chk("one_val_out", int'(val_out), 'h0010);
    chk("one_level", int'(level), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("one_drained", int'(out_valid), 0);
    chk("one_dec", int'(dec_count), 1);

    // Pass-through and wrap-around.
    do_reset();
    val_in = 16'h1234; enable = 1'b0; in_valid = 1'b1;
    tick();
    val_in = 16'h0000; enable = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("wrap_head0", int'(val_out), 'h1234);
    out_ready = 1'b1;
    tick();
    chk("wrap_head1", int'(val_out), 'hFFFF);
    tick();
    out_ready = 1'b0;
    chk("wrap_empty", int'(out_valid), 0);
    chk("wrap_dec", int'(dec_count), 1);
    chk("wrap_n", popped.size(), 2);
    if (popped.size() == 2) begin
      chk("wrap_pop0", popped[0], 'h1234);
      chk("wrap_pop1", popped[1], 'hFFFF);
    end

    // Full and backpressure.
    do_reset();
    begin
      logic [15:0] w [5];
      logic        t [5];
      int          exp_out [5];
      w = '{16'h0005, 16'h8000, 16'hFFFF, 16'h0001, 16'h00A0};
      t = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_out = '{'h0004, 'h8000, 'hFFFE, 'h0000, 'h009F};
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
        val_in = w[i]; enable = t[i];
        tick();
      end
      chk("full_in_ready", int'(in_ready), 0);
      chk("full_level", int'(level), 4);
      val_in = w[4]; enable = t[4];
      tick();
      chk("full_hold_level", int'(level), 4);
      chk("full_hold_head", int'(val_out), 'h0004);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("full_pop_level", int'(level), 3);
      chk("full_pop_ready", int'(in_ready), 1);
      tick();
      in_valid = 1'b0;
      chk("full_refill", int'(level), 4);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("full_n", popped.size(), 5);
      for (int i = 0; i < 5; i++) begin
        if (i < popped.size()) chk("full_order", popped[i], exp_out[i]);
      end
      chk("full_dec", int'(dec_count), 4);
    end

    // Simultaneous push and pop at level 2.
    do_reset();
    in_valid = 1'b1;
    val_in = 16'h00F0; enable = 1'b0;
    tick();
    val_in = 16'h00F1; enable = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      val_in = 16'h0100 + 16'(i); enable = i[0];
      tick();
      chk("sim_level", int'(level), 2);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    out_ready = 1'b0;
    chk("sim_n", popped.size(), 12);
    if (popped.size() == 12) begin
      chk("sim_pop0", popped[0], 'h00F0);
      chk("sim_pop1", popped[1], 'h00F0);
      chk("sim_pop2", popped[2], 'h0100);
      chk("sim_pop3", popped[3], 'h0100);
      chk("sim_pop11", popped[11], 'h0108);
    end

    // Reset mid-operation with a word presented.
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      val_in = 16'h0200 + 16'(i); enable = 1'b1;
      tick();
    end
    out_ready = 1'b1;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1;
    val_in = 16'h0300;
    tick();
    chk("mid_pre_level", int'(level), 3);
    chk("mid_pre_dec", int'(dec_count), 1);
    rst = 1'b1; val_in = 16'h7777;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_level", int'(level), 0);
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_dec", int'(dec_count), 0);
    tick();
    chk("mid_not_stored", int'(level), 0);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
